// File: rtl/ud_ctrl_debounce.sv
// rtl/ud_ctrl_debounce.sv - button debounce to up/down direction level plus prescaled count-enable tick
module ud_ctrl_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic pause,
    output logic UD,
    output logic tick,
    output logic dir_chg
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             btn_state_q, btn_state_d;
    logic             btn_dly_q, btn_dly_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             ud_q, ud_d;
    logic             tick_q, tick_d;
    logic             dir_chg_q, dir_chg_d;
    logic             press;

    // Only s2 is allowed to reach the debounce logic; s1 may be metastable.
    always_comb begin
        s1_d = btn_raw;
        s2_d = s1_q;
    end

    // A level is accepted only after DEB_CYCLES consecutive samples disagree with the current one.
    always_comb begin
        btn_state_d = btn_state_q;
        deb_cnt_d   = deb_cnt_q;
        if (s2_q == btn_state_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            btn_state_d = s2_q;
            deb_cnt_d   = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Releases are debounced too, but only a press flips the direction.
    always_comb begin
        press     = btn_state_q & ~btn_dly_q;
        btn_dly_d = btn_state_q;
        ud_d      = ud_q ^ press;
        dir_chg_d = press;
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        if (!pause) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            btn_state_q <= 1'b0;
            btn_dly_q   <= 1'b0;
            deb_cnt_q   <= '0;
            div_cnt_q   <= '0;
            ud_q        <= 1'b1;
            tick_q      <= 1'b0;
            dir_chg_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            btn_state_q <= btn_state_d;
            btn_dly_q   <= btn_dly_d;
            deb_cnt_q   <= deb_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ud_q        <= ud_d;
            tick_q      <= tick_d;
            dir_chg_q   <= dir_chg_d;
        end
    end

    assign UD      = ud_q;
    assign tick    = tick_q;
    assign dir_chg = dir_chg_q;

endmodule

// File: tb/tb_ud_ctrl_debounce.sv
// tb/tb_ud_ctrl_debounce.sv - self-checking bench for ud_ctrl_debounce
module tb_ud_ctrl_debounce;

    localparam int DEB = 4;
    localparam int DIV = 5;

    logic clk = 1'b0;
    logic reset, btn_raw, pause;
    logic UD, tick, dir_chg;

    always #10 clk = ~clk;

    ud_ctrl_debounce #(.DEB_CYCLES(DEB), .TICK_DIV(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .pause   (pause),
        .UD      (UD),
        .tick    (tick),
        .dir_chg (dir_chg)
    );

    typedef struct {
        logic rst;
        logic btn;
        logic pse;
        logic ud;
        logic tk;
        logic dc;
    } vec_t;

    vec_t tbl[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state: raw/synchronized sample history since the last reset.
    int m_n, m_unp;
    bit m_st, m_stp, m_ud, m_tick, m_dir;
    bit raw_h[$];
    bit s2_h[$];

    int edge_no = 0;
    int dir_seen = 0;
    int last_dir_edge = 0;
    logic [15:0] tick_hist = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic p);
        reset   = r;
        btn_raw = b;
        pause   = p;
        @(posedge clk);
        #1;
        edge_no++;
        if (r) begin
            m_n = 0; m_unp = 0;
            raw_h.delete(); s2_h.delete();
            m_st = 0; m_stp = 0; m_ud = 1; m_tick = 0; m_dir = 0;
        end else begin
            bit press;
            bit flip;
            press = m_st & ~m_stp;
            m_ud  = m_ud ^ press;
            m_dir = press;
            m_stp = m_st;
            m_n++;
            raw_h.push_back(b);
            s2_h.push_back((m_n >= 3) ? raw_h[m_n-3] : 1'b0);
            flip = 0;
            if (m_n >= DEB) begin
                flip = 1;
                for (int i = 0; i < DEB; i++)
                    if (s2_h[m_n-1-i] == m_st) flip = 0;
            end
            if (flip) m_st = ~m_st;
            if (p) m_tick = 0;
            else begin
                m_unp++;
                m_tick = ((m_unp % DIV) == 0);
            end
        end
        check("model", {29'd0, UD, tick, dir_chg}, {29'd0, m_ud, m_tick, m_dir});
        tick_hist = {tick_hist[14:0], tick};
        if (dir_chg === 1'b1) begin
            dir_seen++;
            last_dir_edge = edge_no;
        end
    endtask

    task automatic run(input logic b, input int n, input logic p);
        for (int i = 0; i < n; i++) step(1'b0, b, p);
    endtask

    initial begin
        int base;
        int left;
        vec_t v;
        reset = 1'b1; btn_raw = 1'b0; pause = 1'b0;

        // Reset, tick cadence, and two full press/release cycles.
        for (int i = 0; i < 3; i++) begin
            v.rst = 1; v.btn = 0; v.pse = 0; v.ud = 1; v.tk = 0; v.dc = 0;
            tbl.push_back(v);
        end
        for (int e = 1; e <= 76; e++) begin
            v.rst = 0;
            v.btn = ((e >= 17) && (e <= 36)) || ((e >= 57) && (e <= 76));
            v.pse = 0;
            v.ud  = (e < 23) || (e >= 63);
            v.tk  = ((e % 5) == 0);
            v.dc  = (e == 23) || (e == 63);
            tbl.push_back(v);
        end
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].btn, tbl[i].pse);
            check($sformatf("table_%0d", i), {29'd0, UD, tick, dir_chg},
                  {29'd0, tbl[i].ud, tbl[i].tk, tbl[i].dc});
        end

        // Bounce then steady high: one toggle, 6 edges after the steady run starts.
        step(1'b1, 1'b0, 1'b0);
        run(1'b0, 4, 1'b0);
        dir_seen = 0;
        base = edge_no + 1;
        run(1'b1, 3, 1'b0); run(1'b0, 1, 1'b0); run(1'b1, 2, 1'b0); run(1'b0, 1, 1'b0);
        run(1'b1, 12, 1'b0);
        check("bounce_toggles", dir_seen, 1);
        check("bounce_latency", last_dir_edge - base, 13);
        run(1'b0, 12, 1'b0);
        dir_seen = 0;
        run(1'b1, 3, 1'b0); run(1'b0, 10, 1'b0);
        check("pulse3_toggles", dir_seen, 0);
        base = edge_no + 1;
        run(1'b1, 4, 1'b0); run(1'b0, 12, 1'b0);
        check("pulse4_toggles", dir_seen, 1);
        check("pulse4_latency", last_dir_edge - base, 6);

        // Pause at div_cnt=2 for 7 edges, then resume.
        step(1'b1, 1'b0, 1'b0);
        run(1'b0, 2, 1'b0);
        run(1'b0, 7, 1'b1);
        check("pause_no_tick", tick_hist[6:0], 7'd0);
        run(1'b0, 13, 1'b0);
        check("pause_resume", tick_hist[12:0], 13'b0010000100001);

        // Reset aborts a debounce in progress and restarts the prescaler.
        step(1'b1, 1'b0, 1'b0);
        run(1'b0, 3, 1'b0);
        dir_seen = 0;
        run(1'b1, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(1'b0, 10, 1'b0);
        check("rst_mid_dir", dir_seen, 0);
        check("rst_mid_ud", UD, 1);
        check("rst_mid_tick", tick_hist[9:0], 10'b0000100001);

        // Randomized runs of button levels with sporadic pause and reset.
        left = 600;
        while (left > 0) begin
            logic lvl;
            int len;
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len && left > 0; i++) begin
                step(($urandom_range(0, 199) == 0), lvl, ($urandom_range(0, 9) == 0));
                left--;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
